bfis_query_ctrl: RTL and testbench

- Sequences one `bfis` search engine between a 32-bit host word stream (UART/debug-core side) and a result stream.
- Assembles each query frame: sync word, DIM query elements, k, start vertex id.
- Launches the engine with a 1-cycle valid pulse, then collects exactly k results into an internal FIFO for the host to drain.
- Detects a hung search with a timeout.

---
 rtl/bfis_ctrl_pkg.sv | 12 +
 rtl/bfis_query_ctrl_fifo.sv | 56 +++++
 rtl/bfis_query_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_bfis_query_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfis_ctrl_pkg.sv
// Shared types and constants for the bfis query controller.
package bfis_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, LAUNCH, RUN} ctrl_state_t;

  localparam logic [31:0] SYNC_WORD = 32'hFFFF_FFFF;

  function automatic logic [15:0] clamp_k(input logic [15:0] k, input int unsigned max_k);
    return ({16'd0, k} > 32'(max_k)) ? 16'(max_k) : k;
  endfunction

endpackage

// File: rtl/bfis_query_ctrl_fifo.sv
// First-word-fall-through FIFO; a pop frees its slot in the same cycle a push may reuse it.
module bfis_query_ctrl_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop_in && (count_q != '0);
    do_push  = push_in && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = mem_q[rd_ptr_q];
  assign empty_out = (count_q == '0);

endmodule

// File: rtl/bfis_query_ctrl.sv
// Host-frame sequencer for one bfis search engine with result FIFO and hang timeout.
// Define BFIS_CTRL_CYCLE_COUNT_EN to report launch-to-done cycle counts on cycles_out.
module bfis_query_ctrl
  import bfis_ctrl_pkg::*;
#(
  parameter int unsigned DIM            = 4,
  parameter int unsigned MAX_K          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           host_data_in,
  input  logic                  host_valid_in,
  output logic                  host_ready_out,
  output logic [DIM-1:0][31:0]  eng_query_out,
  output logic [15:0]           eng_k_out,
  output logic [31:0]           eng_vid_out,
  output logic                  eng_valid_out,
  input  logic [31:0]           eng_result_in,
  input  logic                  eng_result_valid_in,
  output logic [31:0]           res_data_out,
  output logic                  res_valid_out,
  input  logic                  res_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  timeout_out,
  output logic [31:0]           cycles_out
);

  localparam int IW = $clog2(DIM + 2);
  localparam logic [IW-1:0] IDX_K = IW'(DIM);

  ctrl_state_t          state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DIM-1:0][31:0] query_q, query_d;
  logic [15:0]          k_q, k_d, rcnt_q, rcnt_d;
  logic [31:0]          vid_q, vid_d, tcnt_q, tcnt_d;
  logic                 eng_valid_q, eng_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 host_fire, fifo_empty, fifo_push;

  assign host_ready_out = rst_in && (((state_q == IDLE) && fifo_empty) || (state_q == LOAD));
  assign host_fire      = host_valid_in && host_ready_out;
  assign fifo_push      = (state_q == RUN) && eng_result_valid_in;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    query_d     = query_q;
    k_d         = k_q;
    vid_d       = vid_q;
    rcnt_d      = rcnt_q;
    tcnt_d      = tcnt_q;
    timeout_d   = timeout_q;
    eng_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_fire && (host_data_in == SYNC_WORD)) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (host_fire) begin
          if (host_data_in == SYNC_WORD) begin
            idx_d = '0;
          end else if (idx_q < IDX_K) begin
            for (int i = 0; i < DIM; i++) begin
              if (idx_q == IW'(i)) query_d[i] = host_data_in;
            end
            idx_d = idx_q + IW'(1);
          end else if (idx_q == IDX_K) begin
            k_d   = clamp_k(host_data_in[15:0], MAX_K);
            idx_d = idx_q + IW'(1);
          end else begin
            // Launch pulse is registered so it lines up with the LAUNCH cycle.
            vid_d       = host_data_in;
            state_d     = LAUNCH;
            eng_valid_d = (k_q != '0);
          end
        end
      end
      LAUNCH: begin
        rcnt_d = '0;
        tcnt_d = '0;
        if (k_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timeout_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        tcnt_d = tcnt_q + 32'd1;
        if (eng_result_valid_in) rcnt_d = rcnt_q + 16'd1;
        if (eng_result_valid_in && ((rcnt_q + 16'd1) == k_q)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      query_q     <= '0;
      k_q         <= '0;
      vid_q       <= '0;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
      eng_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      query_q     <= query_d;
      k_q         <= k_d;
      vid_q       <= vid_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
      eng_valid_q <= eng_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef BFIS_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d, cycles_q, cycles_d;

  always_comb begin
    cyc_d    = cyc_q;
    cycles_d = cycles_q;
    if (state_q == LAUNCH) cyc_d = '0;
    else if (state_q == RUN) cyc_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    // The k==0 completion comes straight from LAUNCH and reports zero.
    if (done_d) cycles_d = (state_q == RUN) ? cyc_d : '0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cyc_q    <= '0;
      cycles_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      cycles_q <= cycles_d;
    end
  end

  assign cycles_out = cycles_q;
`else
  assign cycles_out = '0;
`endif

  bfis_query_ctrl_fifo #(
    .DATA_WIDTH(32),
    .DEPTH     (int'(MAX_K))
  ) u_res_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (fifo_push),
    .data_in  (eng_result_in),
    .pop_in   (res_ready_in),
    .data_out (res_data_out),
    .empty_out(fifo_empty)
  );

  assign res_valid_out = !fifo_empty;
  assign eng_query_out = query_q;
  assign eng_k_out     = k_q;
  assign eng_vid_out   = vid_q;
  assign eng_valid_out = eng_valid_q;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_bfis_query_ctrl.sv
// Directed and randomized checks of bfis_query_ctrl against a frame/queue reference model.
module tb_bfis_query_ctrl;

  localparam int DIM   = 4;
  localparam int MAX_K = 8;
  localparam int TMO   = 50;
  localparam logic [31:0] SYNC = 32'hFFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [31:0]          host_data_in = '0;
  logic                 host_valid_in = 1'b0;
  logic                 host_ready_out;
  logic [DIM-1:0][31:0] eng_query_out;
  logic [15:0]          eng_k_out;
  logic [31:0]          eng_vid_out;
  logic                 eng_valid_out;
  logic [31:0]          eng_result_in = '0;
  logic                 eng_result_valid_in = 1'b0;
  logic [31:0]          res_data_out;
  logic                 res_valid_out;
  logic                 res_ready_in = 1'b1;
  logic                 busy_out, done_out, timeout_out;
  logic [31:0]          cycles_out;

  int checks = 0;
  int failures = 0;
  int launches = 0;
  int dones = 0;
  int since_launch = 0;
  bit rand_ready = 1'b0;

  logic [31:0] exp_q[$];
  int          exp_rem = 0;

  always #5 clk = ~clk;

  bfis_query_ctrl #(.DIM(DIM), .MAX_K(MAX_K), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .rst_in(rst_n),
    .host_data_in(host_data_in), .host_valid_in(host_valid_in), .host_ready_out(host_ready_out),
    .eng_query_out(eng_query_out), .eng_k_out(eng_k_out), .eng_vid_out(eng_vid_out),
    .eng_valid_out(eng_valid_out), .eng_result_in(eng_result_in),
    .eng_result_valid_in(eng_result_valid_in), .res_data_out(res_data_out),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .busy_out(busy_out),
    .done_out(done_out), .timeout_out(timeout_out), .cycles_out(cycles_out)
  );

  always @(negedge clk) begin
    if (eng_valid_out) launches++;
    if (done_out) dones++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the pop/push the coming edge performs, then compare FIFO visibility.
  task automatic step();
    if (res_valid_out && res_ready_in) begin
      if (exp_q.size() == 0) check("pop_unexpected", {31'd0, res_valid_out}, 32'd0);
      else check("pop_data", res_data_out, exp_q.pop_front());
    end
    if (eng_result_valid_in && exp_rem > 0) begin
      exp_q.push_back(eng_result_in);
      exp_rem--;
    end
    @(posedge clk); #1;
    since_launch++;
    check("res_valid", {31'd0, res_valid_out}, {31'd0, exp_q.size() != 0});
    if (rand_ready) res_ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    host_data_in  = w;
    host_valid_in = 1'b1;
    while (!host_ready_out && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("host_ready_wait", {31'd0, host_ready_out}, 32'd1);
    step();
    host_valid_in = 1'b0;
  endtask

  // Reference frame parse: the last sync word starts a fresh body; the body is query, k, vid.
  function automatic void parse(input logic [31:0] w[$], output logic [31:0] q[DIM],
                                output int k, output logic [31:0] vid);
    logic [31:0] body[$];
    logic [31:0] kw;
    foreach (w[i]) begin
      if (w[i] == SYNC) body.delete();
      else body.push_back(w[i]);
    end
    for (int j = 0; j < DIM; j++) q[j] = body[j];
    kw  = body[DIM];
    k   = int'(kw & 32'h0000_FFFF);
    vid = body[DIM+1];
  endfunction

  task automatic do_query(input logic [31:0] frame[$], input logic [31:0] res[$], input bit rand_gap);
    logic [31:0] eq [DIM];
    logic [31:0] evid;
    int kraw, keff, v, l0, gap;
    parse(frame, eq, kraw, evid);
    keff = (kraw > MAX_K) ? MAX_K : kraw;
    foreach (frame[i]) send_word(frame[i]);
    since_launch = 0;
    if (keff == 0) begin
      l0 = launches;
      check("k0_no_launch", {31'd0, eng_valid_out}, 32'd0);
      step();
      check("k0_done", {31'd0, done_out}, 32'd1);
      check("k0_busy", {31'd0, busy_out}, 32'd0);
      check("k0_launch_cnt", 32'(launches), 32'(l0));
      check("k0_cycles", cycles_out, 32'd0);
      return;
    end
    check("launch_pulse", {31'd0, eng_valid_out}, 32'd1);
    for (int j = 0; j < DIM; j++) check("eng_query", eng_query_out[j], eq[j]);
    check("eng_k", {16'd0, eng_k_out}, 32'(keff));
    check("eng_vid", eng_vid_out, evid);
    check("busy_launch", {31'd0, busy_out}, 32'd1);
    exp_rem = keff;
    step();
    check("launch_one_cycle", {31'd0, eng_valid_out}, 32'd0);
    check("timeout_cleared", {31'd0, timeout_out}, 32'd0);
    foreach (res[r]) begin
      gap = rand_gap ? $urandom_range(0, 3) : 0;
      repeat (gap) step();
      eng_result_in       = res[r];
      eng_result_valid_in = 1'b1;
      v = since_launch;
      step();
      eng_result_valid_in = 1'b0;
      if (r == keff - 1) begin
        check("done_pulse", {31'd0, done_out}, 32'd1);
        check("done_idle", {31'd0, busy_out}, 32'd0);
`ifdef BFIS_CTRL_CYCLE_COUNT_EN
        check("cycles", cycles_out, 32'(v));
`else
        check("cycles_tied", cycles_out, 32'd0);
`endif
      end else begin
        check("no_done", {31'd0, done_out}, 32'd0);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    res_ready_in = 1'b1;
    while (exp_q.size() > 0 && n < 4 * MAX_K) begin
      step();
      n++;
    end
    check("drain_empty", {31'd0, res_valid_out}, 32'd0);
  endtask

  initial begin
    logic [31:0] fr[$];
    logic [31:0] rs[$];
    int d0, kr;

    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    check("rst_host_ready", {31'd0, host_ready_out}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_timeout", {31'd0, timeout_out}, 32'd0);
    check("rst_cycles", cycles_out, 32'd0);
    check("rst_eng_valid", {31'd0, eng_valid_out}, 32'd0);
    check("rst_eng_k", {16'd0, eng_k_out}, 32'd0);
    check("rst_eng_vid", eng_vid_out, 32'd0);
    for (int j = 0; j < DIM; j++) check("rst_eng_query", eng_query_out[j], 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_host_ready", {31'd0, host_ready_out}, 32'd1);

    // Normal query
    fr = '{SYNC, 32'd5, 32'd7, 32'd1, 32'd1, 32'd4, 32'd1};
    rs = '{32'd10, 32'd11, 32'd12, 32'd13};
    do_query(fr, rs, 1'b1);
    drain();

    // Sync word mid-frame restarts
    fr = '{SYNC, 32'd5, 32'd7, SYNC, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3, 32'd9};
    rs = '{32'd21, 32'd22, 32'd23};
    do_query(fr, rs, 1'b0);
    drain();

    // k == 0
    fr = '{SYNC, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd6};
    rs = '{};
    do_query(fr, rs, 1'b0);

    // k clamped, ninth result dropped
    fr = '{SYNC, 32'd1, 32'd1, 32'd1, 32'd1, 32'd20, 32'd2};
    rs = '{};
    for (int i = 0; i < MAX_K + 1; i++) rs.push_back(32'h100 + 32'(i));
    do_query(fr, rs, 1'b1);
    drain();

    // Timeout with 2 of 4 results; FIFO retained, host blocked until drained
    res_ready_in = 1'b0;
    fr = '{SYNC, 32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd8};
    rs = '{32'hA1, 32'hA2};
    do_query(fr, rs, 1'b0);
    while (!done_out && since_launch < 2 * TMO) begin
      check("no_early_timeout", {31'd0, timeout_out}, 32'd0);
      step();
    end
    exp_rem = 0;
    check("timeout_at", 32'(since_launch), 32'(TMO + 1));
    check("timeout_flag", {31'd0, timeout_out}, 32'd1);
    check("timeout_idle", {31'd0, busy_out}, 32'd0);
`ifdef BFIS_CTRL_CYCLE_COUNT_EN
    check("timeout_cycles", cycles_out, 32'(TMO));
`endif
    // Backpressure: a waiting sync word is refused while results are pending
    host_data_in = SYNC;
    host_valid_in = 1'b1;
    repeat (4) begin
      step();
      check("bp_host_ready", {31'd0, host_ready_out}, 32'd0);
      check("bp_not_busy", {31'd0, busy_out}, 32'd0);
    end
    host_valid_in = 1'b0;
    check("timeout_fifo_cnt", 32'(exp_q.size()), 32'd2);
    drain();

    // Next launch clears timeout; results overlap pops
    fr = '{SYNC, 32'd9, 32'd8, 32'd7, 32'd6, 32'd4, 32'd5};
    rs = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    do_query(fr, rs, 1'b0);
    drain();

    // Randomized queries with random host drain
    rand_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      fr = '{};
      if ($urandom_range(0, 1) == 1) fr.push_back($urandom & 32'h7FFF_FFFF);
      fr.push_back(SYNC);
      if ($urandom_range(0, 2) == 0) begin
        fr.push_back($urandom & 32'h7FFF_FFFF);
        fr.push_back(SYNC);
      end
      for (int j = 0; j < DIM; j++) fr.push_back($urandom & 32'h7FFF_FFFF);
      kr = $urandom_range(1, 12);
      fr.push_back(($urandom & 32'h7FFF_0000) | 32'(kr));
      fr.push_back($urandom & 32'h7FFF_FFFF);
      rs = '{};
      for (int i = 0; i < ((kr > MAX_K) ? MAX_K : kr); i++) rs.push_back($urandom);
      do_query(fr, rs, 1'b1);
    end
    rand_ready = 1'b0;
    drain();

    // Reset during RUN abandons the query
    fr = '{SYNC, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
    rs = '{32'hC1};
    do_query(fr, rs, 1'b0);
    res_ready_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_rem = 0;
    check("rrst_busy", {31'd0, busy_out}, 32'd0);
    check("rrst_res_valid", {31'd0, res_valid_out}, 32'd0);
    check("rrst_host_ready", {31'd0, host_ready_out}, 32'd0);
    check("rrst_eng_k", {16'd0, eng_k_out}, 32'd0);
    check("rrst_eng_vid", eng_vid_out, 32'd0);
    check("rrst_eng_query0", eng_query_out[0], 32'd0);
    check("rrst_timeout", {31'd0, timeout_out}, 32'd0);
    check("rrst_cycles", cycles_out, 32'd0);
    rst_n = 1'b1;
    d0 = dones;
    res_ready_in = 1'b1;
    eng_result_valid_in = 1'b1;
    eng_result_in = 32'hDEAD;
    repeat (4) step();
    eng_result_valid_in = 1'b0;
    step();
    check("rrst_no_done", 32'(dones), 32'(d0));
    check("rrst_idle_ready", {31'd0, host_ready_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
